// File: rtl/cmp_pipe.sv
// Multi-lane magnitude comparator. Each lane is unsigned or signed, and each result is registered behind a valid/ready handshake.
// Define CMP_PIPE_STATS_EN to add the per-lane saturating result counters and the stats_* ports.
module cmp_pipe #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned CHANNELS = 1,
   parameter int unsigned COUNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] a,
   input  logic [CHANNELS*WIDTH-1:0] b,
   input  logic                      signed_mode,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS-1:0]       greater,
   output logic [CHANNELS-1:0]       equal,
   output logic [CHANNELS-1:0]       lesser
`ifdef CMP_PIPE_STATS_EN
   ,
   input  logic                      stats_clear,
   output logic [CHANNELS*COUNT_W-1:0] stats_gt,
   output logic [CHANNELS*COUNT_W-1:0] stats_eq,
   output logic [CHANNELS*COUNT_W-1:0] stats_lt
`endif
);

   localparam int unsigned FLAG_W = CHANNELS;

   logic              valid_q, valid_d;
   logic [FLAG_W-1:0] gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
   logic [FLAG_W-1:0] gt_c, eq_c, lt_c;
   logic [WIDTH-1:0]  sign_flip;
   logic [WIDTH-1:0]  ka, kb;
   logic              accept, xfer;

   assign in_ready = !flush && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign xfer     = valid_q && out_ready && !flush;

   // Inverting the MSB maps two's-complement order onto unsigned order.
   assign sign_flip = WIDTH'(signed_mode) << (WIDTH - 1);

   always_comb begin
      gt_c = '0;
      eq_c = '0;
      lt_c = '0;
      ka   = '0;
      kb   = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         ka      = a[i*WIDTH +: WIDTH] ^ sign_flip;
         kb      = b[i*WIDTH +: WIDTH] ^ sign_flip;
         gt_c[i] = ka > kb;
         eq_c[i] = ka == kb;
         lt_c[i] = ka < kb;
      end
   end

   always_comb begin
      valid_d = valid_q;
      gt_d    = gt_q;
      eq_d    = eq_q;
      lt_d    = lt_q;
      if (flush) begin
         valid_d = 1'b0;
         gt_d    = '0;
         eq_d    = '0;
         lt_d    = '0;
      end else if (accept) begin
         valid_d = 1'b1;
         gt_d    = gt_c;
         eq_d    = eq_c;
         lt_d    = lt_c;
      end else if (xfer) begin
         valid_d = 1'b0;
         gt_d    = '0;
         eq_d    = '0;
         lt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         gt_q    <= '0;
         eq_q    <= '0;
         lt_q    <= '0;
      end else begin
         valid_q <= valid_d;
         gt_q    <= gt_d;
         eq_q    <= eq_d;
         lt_q    <= lt_d;
      end
   end

   assign out_valid = valid_q;
   assign greater   = gt_q;
   assign equal     = eq_q;
   assign lesser    = lt_q;

`ifdef CMP_PIPE_STATS_EN
   logic [CHANNELS*COUNT_W-1:0] sgt_q, sgt_d, seq_q, seq_d, slt_q, slt_d;

   // Count only the result being handed over; clear takes priority over a same-cycle increment.
   always_comb begin
      sgt_d = sgt_q;
      seq_d = seq_q;
      slt_d = slt_q;
      if (stats_clear) begin
         sgt_d = '0;
         seq_d = '0;
         slt_d = '0;
      end else if (xfer) begin
         for (int i = 0; i < int'(CHANNELS); i++) begin
            if (gt_q[i] && (sgt_q[i*COUNT_W +: COUNT_W] != {COUNT_W{1'b1}}))
               sgt_d[i*COUNT_W +: COUNT_W] = sgt_q[i*COUNT_W +: COUNT_W] + COUNT_W'(1);
            if (eq_q[i] && (seq_q[i*COUNT_W +: COUNT_W] != {COUNT_W{1'b1}}))
               seq_d[i*COUNT_W +: COUNT_W] = seq_q[i*COUNT_W +: COUNT_W] + COUNT_W'(1);
            if (lt_q[i] && (slt_q[i*COUNT_W +: COUNT_W] != {COUNT_W{1'b1}}))
               slt_d[i*COUNT_W +: COUNT_W] = slt_q[i*COUNT_W +: COUNT_W] + COUNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sgt_q <= '0;
         seq_q <= '0;
         slt_q <= '0;
      end else begin
         sgt_q <= sgt_d;
         seq_q <= seq_d;
         slt_q <= slt_d;
      end
   end

   assign stats_gt = sgt_q;
   assign stats_eq = seq_q;
   assign stats_lt = slt_q;
`endif

endmodule
